// File: rtl/ws_result_collector_if.sv
// ws_result_collector_if
//   Bundles the stream-side signals of the systolic-array result collector.
//   Parameters COLS and ACC_WIDTH must match the collector instance.
//
//   Signals:
//     enable    array advance strobe (same as the PE enable)
//     in_valid  column 0 of c_in carries a valid result row this cycle
//     c_in      bottom-row PE outputs; column j at [j*ACC_WIDTH +: ACC_WIDTH]
//     space_ok  controller may inject a new row
//     out_valid out_data holds a complete aligned row
//     out_ready downstream accepts the row
//     out_data  aligned result row, same column packing as c_in
//     overflow  sticky: a completed row was dropped on a full FIFO
//
//   Modports:
//     master  the collector itself
//     slave   array controller and downstream consumer
interface ws_result_collector_if #(
  parameter int COLS      = 4,
  parameter int ACC_WIDTH = 32
);
  logic                      enable;
  logic                      in_valid;
  logic [COLS*ACC_WIDTH-1:0] c_in;
  logic                      space_ok;
  logic                      out_valid;
  logic                      out_ready;
  logic [COLS*ACC_WIDTH-1:0] out_data;
  logic                      overflow;

  modport master (
    input  enable, in_valid, c_in, out_ready,
    output space_ok, out_valid, out_data, overflow
  );

  modport slave (
    output enable, in_valid, c_in, out_ready,
    input  space_ok, out_valid, out_data, overflow
  );
endinterface

// File: rtl/ws_result_collector.sv
// ws_result_collector
//   Output-side collector for the weight-stationary systolic array. Removes
//   the one-cycle-per-column skew of the bottom PE row, buffers completed rows
//   in a circular FIFO and presents them on a valid/ready stream. Provides the
//   space_ok credit the array controller must respect before injecting a row.
//
//   Ports:
//     clk  clock
//     rst  asynchronous, active-high reset
//     bus  ws_result_collector_if.master (enable, in_valid, c_in, space_ok,
//          out_valid, out_ready, out_data, overflow)
//
//   Parameters: COLS (>=1), ACC_WIDTH, FIFO_DEPTH (>=1; >=COLS for full rate)
//
//   Optional feature: define WS_COLLECT_RELU_EN to clamp negative column
//   values to zero as rows are written into the FIFO.
module ws_result_collector #(
  parameter int COLS       = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  ws_result_collector_if.master bus
);
  localparam int ROW_W = COLS * ACC_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ACC_WIDTH-1:0] aligned [COLS];
  logic                 last_valid;
  logic [31:0]          inflight;

  // The last column arrives exactly when the row is complete, so it bypasses
  // any delay line.
  assign aligned[COLS-1] = bus.c_in[(COLS-1)*ACC_WIDTH +: ACC_WIDTH];

  // Column j waits COLS-1-j enabled edges so that all columns of a row meet
  // at the edge where column COLS-1 is presented.
  for (genvar j = 0; j < COLS - 1; j++) begin : g_deskew
    localparam int DEPTH = COLS - 1 - j;
    logic [ACC_WIDTH-1:0] line [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < DEPTH; k++) line[k] <= '0;
      end else if (bus.enable) begin
        line[0] <= bus.c_in[j*ACC_WIDTH +: ACC_WIDTH];
        for (int k = 1; k < DEPTH; k++) line[k] <= line[k-1];
      end
    end

    assign aligned[j] = line[DEPTH-1];
  end

  // Valid pipeline travels with column 0; its population is the number of
  // rows already committed to the FIFO but not yet written.
  if (COLS > 1) begin : g_vpipe
    logic [COLS-2:0] vpipe;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vpipe <= '0;
      end else if (bus.enable) begin
        vpipe[0] <= bus.in_valid;
        for (int k = 1; k < COLS - 1; k++) vpipe[k] <= vpipe[k-1];
      end
    end

    assign last_valid = vpipe[COLS-2];
    assign inflight   = 32'($countones(vpipe));
  end else begin : g_no_vpipe
    assign last_valid = bus.in_valid;
    assign inflight   = '0;
  end

  // Row as written into the FIFO (optionally rectified).
  logic [ROW_W-1:0] write_row;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    write_row = '0;
    for (int j = 0; j < COLS; j++) begin
`ifdef WS_COLLECT_RELU_EN
      write_row[j*ACC_WIDTH +: ACC_WIDTH] = aligned[j][ACC_WIDTH-1] ? '0 : aligned[j];
`else
      write_row[j*ACC_WIDTH +: ACC_WIDTH] = aligned[j];
`endif
    end
  end

  // Result-row FIFO: circular buffer with explicit occupancy count.
  logic [ROW_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow_q;
  logic             not_empty;
  logic             full;
  logic             push_req;
  logic             do_push;
  logic             do_pop;
  logic             drop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign not_empty = (count != '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign push_req  = bus.enable && last_valid;
  assign do_pop    = not_empty && bus.out_ready;
  // A pop in the same edge frees the slot the push needs.
  assign do_push   = push_req && (!full || do_pop);
  assign drop      = push_req && full && !do_pop;

  // NOTE: the storage array is deliberately not reset; out_data is masked
  // while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= write_row;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign bus.out_valid = not_empty;
  assign bus.out_data  = not_empty ? mem[rd_ptr] : '0;
  assign bus.overflow  = overflow_q;
  // Credit counts rows still in the deskew pipeline, using registered state
  // only, so it never reacts combinationally to in_valid or out_ready.
  assign bus.space_ok  = (32'(count) + inflight) < 32'(FIFO_DEPTH);

endmodule

// File: tb/tb_ws_result_collector.sv
// tb_ws_result_collector
//   Self-checking bench for ws_result_collector (COLS=4, ACC_WIDTH=32,
//   FIFO_DEPTH=4). A row model tracks each issued row by the enabled-edge
//   index at which its last column arrives, then a plain queue models the
//   result FIFO. Outputs are compared against the model every cycle, with
//   hand-computed literal checks at the key points.
module tb_ws_result_collector;
  localparam int COLS       = 4;
  localparam int ACC_WIDTH  = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int ROW_W      = COLS * ACC_WIDTH;

  typedef logic [ROW_W-1:0] row_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ws_result_collector_if #(.COLS(COLS), .ACC_WIDTH(ACC_WIDTH)) bus ();

  ws_result_collector #(
    .COLS      (COLS),
    .ACC_WIDTH (ACC_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state
  row_t           exp_q[$];       // rows in the FIFO, head first
  row_t           pend[int];      // completion edge index -> expected row
  row_t           colsched[int];  // enabled edge index -> scheduled column values
  logic [COLS-1:0] colmask[int];  // which columns are scheduled at that edge
  bit             exp_ovf = 1'b0;
  int             en_idx  = 0;    // index of the next enabled edge
  row_t           cur_row;

  task automatic check(input string name, input row_t act, input row_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic row_t relu_row(input row_t r);
    row_t v;
    v = r;
`ifdef WS_COLLECT_RELU_EN
    for (int j = 0; j < COLS; j++)
      if (r[j*ACC_WIDTH + ACC_WIDTH - 1]) v[j*ACC_WIDTH +: ACC_WIDTH] = '0;
`endif
    return v;
  endfunction

  function automatic bit exp_space_ok();
    return (exp_q.size() + pend.num()) < FIFO_DEPTH;
  endfunction

  function automatic row_t rand_row();
    row_t r;
    for (int j = 0; j < COLS; j++) r[j*ACC_WIDTH +: ACC_WIDTH] = $urandom;
    return r;
  endfunction

  // c_in at enabled edge e: scheduled column values, otherwise a fixed
  // per-edge filler (stable while enable is low).
  function automatic row_t compose(input int e);
    row_t v;
    row_t s;
    logic [COLS-1:0] m;
    s = colsched.exists(e) ? colsched[e] : '0;
    m = colmask.exists(e) ? colmask[e] : '0;
    for (int j = 0; j < COLS; j++)
      v[j*ACC_WIDTH +: ACC_WIDTH] = m[j] ? s[j*ACC_WIDTH +: ACC_WIDTH]
                                         : ACC_WIDTH'(32'hA5A5_0000 ^ (e * 31 + j));
    return v;
  endfunction

  // Column j of a row issued at enabled edge n appears at enabled edge n+j.
  task automatic schedule(input row_t row);
    int k;
    row_t s;
    logic [COLS-1:0] m;
    for (int j = 0; j < COLS; j++) begin
      k = en_idx + j;
      s = colsched.exists(k) ? colsched[k] : '0;
      m = colmask.exists(k) ? colmask[k] : '0;
      s[j*ACC_WIDTH +: ACC_WIDTH] = row[j*ACC_WIDTH +: ACC_WIDTH];
      m[j] = 1'b1;
      colsched[k] = s;
      colmask[k]  = m;
    end
  endtask

  // One clock cycle with the given inputs; returns 1 time unit after the edge.
  task automatic cycle(input logic en, input logic iv, input row_t row, input logic rdy);
    bus.enable    = en;
    bus.in_valid  = iv;
    bus.out_ready = rdy;
    if (en && iv) begin
      schedule(row);
      cur_row = row;
    end
    bus.c_in = compose(en_idx);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.enable    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #2;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_space_ok",  bus.space_ok,  1'b1);
    check("rst_overflow",  bus.overflow,  1'b0);
    check("rst_out_data",  bus.out_data,  '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Behavioural model of the whole block.
  always @(posedge clk or posedge rst) begin : model
    bit   pop_now;
    bit   push_now;
    bit   full_now;
    row_t prow;
    if (rst) begin
      exp_q.delete();
      pend.delete();
      colsched.delete();
      colmask.delete();
      exp_ovf = 1'b0;
    end else begin
      pop_now  = (exp_q.size() != 0) && bus.out_ready;
      full_now = (exp_q.size() == FIFO_DEPTH);
      push_now = 1'b0;
      prow     = '0;
      if (bus.enable) begin
        if (bus.in_valid) pend[en_idx + COLS - 1] = relu_row(cur_row);
        if (pend.exists(en_idx)) begin
          push_now = 1'b1;
          prow     = pend[en_idx];
          pend.delete(en_idx);
        end
        en_idx++;
      end
      if (pop_now) void'(exp_q.pop_front());
      if (push_now) begin
        if (full_now && !pop_now) exp_ovf = 1'b1;
        else                      exp_q.push_back(prow);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("out_valid", bus.out_valid, exp_q.size() != 0);
      check("out_data",  bus.out_data,  (exp_q.size() != 0) ? exp_q[0] : '0);
      check("space_ok",  bus.space_ok,  exp_space_ok());
      check("overflow",  bus.overflow,  exp_ovf);
    end
  end

  initial begin
    int   cnt;
    int   first;
    int   last;
    int   issued;
    row_t r;
    row_t relu_exp;

    bus.enable    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.c_in      = '0;
    #1;
    do_reset();
    chk_en = 1'b1;

    // Reset in mid-stream: 2 rows buffered, 2 in the deskew pipeline.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, rand_row(), 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    check("mid_pre_space_ok", bus.space_ok,  1'b0);
    check("mid_pre_valid",    bus.out_valid, 1'b1);
    do_reset();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b1);
      if (bus.out_valid) cnt++;
    end
    check("post_rst_no_output", cnt, 0);

    // Single row: column j = 10+j, latency COLS.
    r = {32'd13, 32'd12, 32'd11, 32'd10};
    cycle(1'b1, 1'b1, r, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1);
    check("single_t3_valid", bus.out_valid, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1);
    check("single_t4_valid", bus.out_valid, 1'b1);
    check("single_t4_data",  bus.out_data,  {32'd13, 32'd12, 32'd11, 32'd10});
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b1);

    // Enable gap in cycles t+1 and t+2: output in t+6.
    cycle(1'b1, 1'b1, r, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1);
    check("gap_t5_valid", bus.out_valid, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1);
    check("gap_t6_valid", bus.out_valid, 1'b1);
    check("gap_t6_data",  bus.out_data,  {32'd13, 32'd12, 32'd11, 32'd10});
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b1);

    // Back-to-back: 8 rows on consecutive cycles.
    cnt   = 0;
    first = -1;
    last  = -1;
    for (int i = 0; i < 20; i++) begin
      if (i < 8) cycle(1'b1, 1'b1, rand_row(), 1'b1);
      else       cycle(1'b1, 1'b0, '0, 1'b1);
      if (bus.out_valid) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check("b2b_count",    cnt, 8);
    check("b2b_contig",   last - first + 1, 8);
    check("b2b_overflow", bus.overflow, 1'b0);

    // Backpressure: issue only while space_ok, exactly FIFO_DEPTH accepted.
    issued = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.space_ok) begin
        cycle(1'b1, 1'b1, rand_row(), 1'b0);
        issued++;
      end else begin
        cycle(1'b1, 1'b0, '0, 1'b0);
      end
    end
    check("bp_accepted", issued, FIFO_DEPTH);
    check("bp_space_ok", bus.space_ok, 1'b0);

    // Forced overflow: 5th row with a full FIFO is dropped.
    cycle(1'b1, 1'b1, rand_row(), 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    check("ovf_set", bus.overflow, 1'b1);

    // Push and pop on the same edge while full.
    cycle(1'b1, 1'b1, rand_row(), 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    check("full_pp_space_ok", bus.space_ok,  1'b0);
    check("full_pp_valid",    bus.out_valid, 1'b1);
    check("ovf_sticky",       bus.overflow,  1'b1);

    // Drain: four rows leave in order and credit returns.
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) cnt++;
      cycle(1'b1, 1'b0, '0, 1'b1);
    end
    check("drain_count",    cnt, FIFO_DEPTH);
    check("drain_space_ok", bus.space_ok, 1'b1);

    do_reset();

    // Rectifier row: column 3 is -5, column 0 is 0.
    r = {32'hFFFF_FFFB, 32'd7, 32'h8000_0000, 32'd0};
`ifdef WS_COLLECT_RELU_EN
    relu_exp = {32'd0, 32'd7, 32'd0, 32'd0};
`else
    relu_exp = {32'hFFFF_FFFB, 32'd7, 32'h8000_0000, 32'd0};
`endif
    cycle(1'b1, 1'b1, r, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b1);
    check("relu_valid", bus.out_valid, 1'b1);
    check("relu_data",  bus.out_data,  relu_exp);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b1);

    // Randomised traffic respecting the credit.
    for (int i = 0; i < 400; i++) begin
      logic en;
      logic iv;
      logic rdy;
      en  = ($urandom_range(0, 9) < 8);
      rdy = ($urandom_range(0, 9) < 7);
      iv  = en && exp_space_ok() && ($urandom_range(0, 1) == 1);
      cycle(en, iv, rand_row(), rdy);
    end
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, '0, 1'b1);
    check("final_empty",    bus.out_valid, 1'b0);
    check("final_overflow", bus.overflow,  1'b0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ws_result_collector.md
# ws_result_collector

Output-side collector for the weight-stationary systolic array. It takes the partial-sum outputs from the bottom row of PEs, one per column, and removes the one-cycle-per-column skew so a whole result row lines up. It then buffers completed rows in a FIFO and presents them downstream on a valid/ready stream. It also gives the array controller the credit signal (`space_ok`) it must respect before injecting a new A row.

## Interface
Parameters:
- COLS, 4, number of array columns (≥1)
- ACC_WIDTH, 32, width of each column result (signed)
- FIFO_DEPTH, 4, result-row FIFO entries (≥1; ≥COLS for full throughput)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  array advance strobe; same signal that drives the PE `enable`
- in_valid  in  1  column 0 of `c_in` carries a valid result row this cycle
- c_in  in  COLS*ACC_WIDTH  bottom-row PE outputs; column j in bits [j*ACC_WIDTH +: ACC_WIDTH]
- space_ok  out  1  controller may assert `in_valid` for a new row
- out_valid  out  1  `out_data` holds a complete row
- out_ready  in  1  downstream accepts the row
- out_data  out  COLS*ACC_WIDTH  aligned result row, same column packing as `c_in`
- overflow  out  1  sticky: a completed row was dropped because the FIFO was full

## Operation
- Skew model: for a row whose column-0 value is presented with `in_valid=1` on enabled edge e0, column j's value is on `c_in` at enabled edge e_j.
- Deskew: column j passes through a delay line of COLS-1-j registers. Column COLS-1 is used combinationally.
  - A valid pipeline of COLS-1 stages carries `in_valid` alongside the data.
  - All deskew and valid registers shift only on edges where `enable=1`. On edges with `enable=0` they hold.
  - `in_valid` is ignored when `enable=0`.
- Push: on an enabled edge where the last valid stage is 1, the aligned row is written to the FIFO. For COLS=1, the last valid stage is `in_valid` itself.
  - Column COLS-1 comes from `c_in`; the other columns come from their delay lines.
- Pop: `out_valid = (count != 0)`. The head row is popped on any edge with `out_valid && out_ready`. Pop is independent of `enable`.
- Credit:
  - `inflight` = number of set bits in the valid pipeline.
  - `space_ok = (count + inflight < FIFO_DEPTH)`, computed from registered state only.
  - The controller asserts `in_valid` only when `space_ok=1`.
- FIFO implementation: circular buffer with wrap-around read/write pointers and an occupancy count of 0..FIFO_DEPTH.
- Simultaneous push and pop while full: both happen, count stays FIFO_DEPTH, no overflow.
- Push while full without a pop: the row is dropped, FIFO contents are unchanged, and `overflow` is set to 1. `overflow` stays 1 until reset.
- Arithmetic: none in the base block. Values pass through bit-exact as signed ACC_WIDTH.

## Timing
- Reset values, asserted asynchronously:
  - Deskew data registers 0, valid pipeline 0.
  - FIFO pointers and count 0.
  - `out_valid=0`, `out_data=0`, `overflow=0`, `space_ok=1`.
- Reset in mid-operation discards every in-flight and buffered row. No partial row is emitted after reset releases.
- Latency with `enable` held high and the FIFO empty: `in_valid` in cycle t → `out_valid=1` in cycle t+COLS, with the full aligned row on `out_data`.
- Each `enable=0` cycle adds one cycle of latency to rows still in the deskew pipeline. It does not delay rows already in the FIFO.
- Throughput: one row per cycle is sustained when FIFO_DEPTH ≥ COLS and `out_ready=1`.
- `out_data` is the FIFO head and holds stable while `out_valid && !out_ready`.
- `space_ok` is registered-state based. It never rises or falls combinationally from `in_valid` or `out_ready`.

## Configuration
- `WS_COLLECT_RELU_EN`
  - Defined: each column value is clamped to 0 if negative (MSB=1) as it is written into the FIFO. Non-negative values pass unchanged. Latency is unchanged.
  - Undefined: values pass through bit-exact and no clamp logic is present.

## Test plan
- Reset mid-stream, then a single row:
  - Assert rst with two rows in flight → `out_valid=0`, `space_ok=1`, `overflow=0`; after release, no spurious output.
  - COLS=4, `enable=1`: drive column j with value 10+j in cycle t+j and `in_valid` in cycle t → `out_valid` in t+4, `out_data` = {13,12,11,10} (column 3 in the top field, column 0 in the bottom field).
- Back-to-back rows with `out_ready=1`: 8 rows on consecutive cycles → 8 consecutive `out_valid` cycles, rows in order, `overflow=0`.
- Enable gaps: the same row as the single-row test with `enable=0` in cycles t+1 and t+2, `c_in` held constant for those two cycles → `out_valid` in t+6, `out_data` = {13,12,11,10}.
- Backpressure and credit:
  - `out_ready=0`, FIFO_DEPTH=4: issue rows while `space_ok=1` → exactly 4 rows accepted, then `space_ok=0`.
  - Raise `out_ready`: rows drain in order, `space_ok` returns to 1, and pointers wrap cleanly.
- Forced overflow: ignore `space_ok` and issue a 5th row with the FIFO full and `out_ready=0` → that row is dropped and `overflow=1`, sticky. Then push and pop in the same cycle while full → count stays 4 and no further drop occurs.
- ReLU: with `WS_COLLECT_RELU_EN` defined, a row {-5,7,-2147483648,0} → {0,7,0,0}. With it undefined, the same row passes through unchanged.
